// File: rtl/dmem_responder.sv
// dmem_responder: slave end of a valid/ready data-memory interface.
// Word-organised little-endian RAM. One transaction at a time, a programmable
// wait between acceptance and response, and the response held until taken.
// Optional build macro DMEM_ERR_COUNT_EN adds a saturating 16-bit fault counter.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             acc_wr;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [1:0]       acc_size;
    logic             acc_uns;
    logic [31:0]      acc_off;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_fault;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      store_shift;
    logic [3:0]       lane_en;
    logic [31:0]      merged;

    // Select access operands; with zero latency the commit happens on the
    // acceptance edge itself, so the live request fields are used.
    always_comb begin
        accept     = (state_q == StIdle) && req_valid && req_ready;
        enter_resp = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd0));
        if (state_q == StIdle) begin
            acc_wr    = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
        end
    end

    // Fault detection, load extraction and store read-modify-write merge.
    always_comb begin
        // ADDR_BASE is aligned, so acc_off[1:0] equals the address lane bits
        acc_off   = acc_addr - ADDR_BASE;
        acc_idx   = acc_off[IDX_W+1:2];
        acc_fault = (acc_size == 2'b11)
                  | ((acc_size == 2'b01) && acc_off[0])
                  | ((acc_size == 2'b10) && (acc_off[1:0] != 2'b00))
                  | (acc_off[31:IDX_W+2] != '0);
        rd_word   = mem[acc_idx];
        rd_byte   = rd_word[{acc_off[1:0], 3'b000} +: 8];
        rd_half   = rd_word[{acc_off[1], 4'b0000} +: 16];
        load_data = rd_word;
        lane_en   = 4'b1111;
        case (acc_size)
            2'b00: begin
                load_data = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                lane_en   = 4'b0001 << acc_off[1:0];
            end
            2'b01: begin
                load_data = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                lane_en   = 4'b0011 << {acc_off[1], 1'b0};
            end
            default: begin
                load_data = rd_word;
                lane_en   = 4'b1111;
            end
        endcase
        store_shift = acc_wdata << {acc_off[1:0], 3'b000};
        merged      = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) merged[8*b +: 8] = store_shift[8*b +: 8];
        end
    end

    // FSM, registered outputs, RAM commit and optional fault counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
`ifdef DMEM_ERR_COUNT_EN
            err_count  <= 16'h0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (enter_resp) begin
                resp_err   <= acc_fault;
                resp_rdata <= (acc_fault || acc_wr) ? 32'h0 : load_data;
                if (acc_wr && !acc_fault) mem[acc_idx] <= merged;
`ifdef DMEM_ERR_COUNT_EN
                if (acc_fault && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written multi-cycle
// sequences (held response, reset during WAIT) and random traffic checked
// against a byte-array reference memory.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_errcnt;
    logic [7:0]  ref_mem [0:1023];

    dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (LAT),
        .ADDR_BASE  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
`ifdef DMEM_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1);
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        exp_errcnt = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Reference: RAM viewed as a flat little-endian byte array.
    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic u,
                                  output logic [31:0] rd, output logic e);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
             || (a >= 32'd1024);
        rd = 32'h0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
            if (!u && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!u && nb == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    // One complete transaction with latency, busy and hold-stability checks.
    task automatic txn(input string nm, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic u,
                       input logic [31:0] exp_rd, input logic exp_e);
        int   n;
        int   lat;
        int   hold;
        logic rdy_bad;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = u;
        resp_ready   = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1({nm, " accept_ready"}, req_ready, 1'b1);
        @(negedge clk);
        // Garbage on the request bus while busy must be ignored
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        lat     = 0;
        rdy_bad = 1'b0;
        while (!resp_valid && lat < 20) begin
            if (req_ready) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk32({nm, " latency"}, 32'(lat), 32'(LAT));
        chk1({nm, " ready_low_busy"}, rdy_bad | req_ready, 1'b0);
        chk32({nm, " rdata"}, resp_rdata, exp_rd);
        chk1({nm, " err"}, resp_err, exp_e);
        hold = int'($urandom_range(0, 2));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1({nm, " hold_valid"}, resp_valid, 1'b1);
            chk32({nm, " hold_rdata"}, resp_rdata, exp_rd);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk1({nm, " post_hs_valid"}, resp_valid, 1'b0);
        chk1({nm, " post_hs_ready"}, req_ready, 1'b1);
`ifdef DMEM_ERR_COUNT_EN
        if (exp_e) exp_errcnt = exp_errcnt + 16'd1;
        chk32({nm, " err_count"}, {16'h0, err_count}, {16'h0, exp_errcnt});
`endif
    endtask

    typedef struct {
        logic        rst_before;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] exp_rd;
        logic        exp_e;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int          n;
        logic        w;
        logic        u;
        logic        e;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        resp_ready   = 1'b0;
        clear_model();

        vecs[0]  = '{1'b1, 1'b1, 32'h21,  32'h80,       2'b00, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h21,  32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h21,  32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h00008000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h13,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h12,  32'h1234,     2'b10, 1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        2'b11, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h10,  32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h12,  32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h13,  32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h22,  32'hA5A57FFF, 2'b01, 1'b0, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h7FFF8000, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk1("reset req_ready", req_ready, 1'b1);
        chk1("reset resp_valid", resp_valid, 1'b0);
        chk32("reset resp_rdata", resp_rdata, 32'h0);
        chk1("reset resp_err", resp_err, 1'b0);
`ifdef DMEM_ERR_COUNT_EN
        chk32("reset err_count", {16'h0, err_count}, 32'h0);
`endif

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_before) do_reset();
            txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].sz,
                vecs[i].u, vecs[i].exp_rd, vecs[i].exp_e);
        end

        // Held response while a different request waits on the bus
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        resp_ready   = 1'b0;
        chk1("hold ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_addr = 32'h20;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk32("hold latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            chk1("hold s5_valid", resp_valid, 1'b1);
            chk32("hold s5_rdata", resp_rdata, 32'hDEADBEEF);
            chk1("hold s5_err", resp_err, 1'b0);
            chk1("hold s5_ready_low", req_ready, 1'b0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk1("hold s5_post_valid", resp_valid, 1'b0);
        chk1("hold s5_post_ready", req_ready, 1'b1);
        @(negedge clk);
        chk1("hold s5_second_accepted", req_ready, 1'b0);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk32("hold s5_second_latency", 32'(n), 32'(LAT));
        chk32("hold s5_second_rdata", resp_rdata, 32'h7FFF8000);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk1("hold s5_second_done", resp_valid, 1'b0);

        // Reset during WAIT aborts an uncommitted store
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        req_size   = 2'b10;
        chk1("abort ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk1("abort busy", req_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        chk1("abort req_ready", req_ready, 1'b1);
        chk1("abort resp_valid", resp_valid, 1'b0);
        chk32("abort resp_rdata", resp_rdata, 32'h0);
`ifdef DMEM_ERR_COUNT_EN
        chk32("abort err_count", {16'h0, err_count}, 32'h0);
`endif
        txn("abort load40", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
        txn("abort load10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);

        // Random traffic against the byte-array model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            model(w, a, wd, sz, u, rd, e);
            txn($sformatf("rand%0d", i), w, a, wd, sz, u, rd, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
